shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one combinational 32-bit barrel shifter between two requesters (ports 0 and 1).
- Arbitrates round-robin, registers the granted operands, drives the shifter and captures its result.
- Returns the result on one response channel tagged with the requester id, under a valid/ready handshake.
- Sits between the ALU-side issue logic and the shared shifter instance.

Parameters:
PRIO_INIT, 0, requester holding priority after reset (0 or 1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  requester 0 operand
req0_b  in  5  requester 0 shift amount
req0_aluc  in  2  requester 0 op: 00 arithmetic right, 01 logical right, 10/11 left
req1_valid, req1_ready, req1_a, req1_b, req1_aluc  same as requester 0, for requester 1
sh_a  out  32  operand to shared shifter
sh_b  out  5  shift amount to shared shifter
sh_aluc  out  2  op to shared shifter
sh_c  in  32  shifter result (combinational from sh_a/sh_b/sh_aluc)
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester that owns the result
resp_c  out  32  registered shift result
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Reset (rst_n low, asynchronous) forces:
  - state = IDLE, prio = PRIO_INIT;
  - op_a/op_b/op_aluc/op_id = 0, resp_c = 0, resp_id = 0;
  - resp_valid = 0, busy = 0, req0_ready = req1_ready = 0, sh_a = 0, sh_b = 0, sh_aluc = 0.
- IDLE:
  - Grant is combinational.
  - Only one valid: grant it.
  - Both valid: grant prio.
  - reqN_ready = 1 only for the granted requester, and only in IDLE.
  - At the edge with a grant:
    - latch op_a/op_b/op_aluc/op_id;
    - prio <= ~granted id;
    - go to EXEC.
  - No valid: stay; prio unchanged.
- EXEC:
  - sh_a/sh_b/sh_aluc = op registers; these are driven from registers in all states, so they are glitch-free.
  - At the edge: resp_c <= sh_c, resp_id <= op_id, resp_valid <= 1, go to RESP.
- RESP:
  - resp_valid, resp_c and resp_id are held stable until resp_ready = 1.
  - On an edge with resp_valid & resp_ready: resp_valid <= 0, go to IDLE.
- Latency and throughput:
  - Grant in cycle N; resp_valid is high from cycle N+2.
  - Minimum 3 cycles per operation; no overlap between operations.
- Requester rules:
  - A requester must hold its valid and fields stable until ready.
  - Fields are sampled only on the ready cycle; later changes are ignored.
- Back-pressure: resp_ready low holds RESP indefinitely; both req*_ready stay 0 meanwhile.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1... starting at PRIO_INIT.
- Simultaneous events: a new request arriving in the same cycle as the RESP handshake is not granted until the following IDLE cycle.
- Reset mid-operation: any in-flight op is discarded, no response is produced, and prio returns to PRIO_INIT.
- Shifter semantics (owned by the shifter, checked end to end):
  - 00: arithmetic right by b, sign-fill.
  - 01: logical right by b, zero-fill.
  - 10/11: left by b, zero-fill.
  - b = 0 passes a unchanged.

Test Plan:
- Single req0 (a=32'h8000_0000, b=4, aluc=00), resp_ready=1 -> req0_ready high in grant cycle; resp_valid 2 cycles later with resp_c=32'hF800_0000, resp_id=0.
- Single req1 (a=32'h8000_0000, b=4, aluc=01), then (a=1, b=31, aluc=11) -> resp_c=32'h0800_0000 then 32'h8000_0000, resp_id=1 both.
- Both valid continuously, PRIO_INIT=0, 4 ops, resp_ready=1 -> resp_id sequence 0,1,0,1; each op 3 cycles apart.
- resp_ready held 0 for 5 cycles after resp_valid -> resp_c/resp_id stable, req0_ready=req1_ready=0, busy=1; the next grant is issued only in the IDLE cycle after the handshake.
- rst_n asserted asynchronously during EXEC -> all outputs 0 immediately; no response ever appears for that op; the next op is granted to PRIO_INIT.
- b=0 with a=32'hDEAD_BEEF for each aluc 00/01/10/11 -> resp_c=32'hDEAD_BEEF in all four cases.

Source files
------------

// File: rtl/shift_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational barrel shifter between two requesters.
// Latency: grant in cycle N, registered result valid from cycle N+2; at most one operation in flight.
// Backpressure: resp_ready low holds the result in RESP; no new grant until the response handshake.
module shift_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_b,
    input  logic [1:0]  req0_aluc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_b,
    input  logic [1:0]  req1_aluc,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_b,
    output logic [1:0]  sh_aluc,
    input  logic [31:0] sh_c,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_c,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
        logic        id;
    } op_t;

    state_t state;
    state_t state_nxt;
    op_t    op_q;
    logic   prio;
    logic   grant_any;
    logic   grant_id;
    logic   grant_fire;
    logic   resp_fire;

    // Contention resolves to prio; a lone requester wins regardless of prio.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign grant_fire = (state == IDLE) && grant_any;
    assign resp_fire  = resp_valid && resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_fire) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are qualified by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req0_ready = rst_n & grant_fire & ~grant_id;
        req1_ready = rst_n & grant_fire & grant_id;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            prio       <= PRIO_INIT;
            resp_c     <= '0;
            resp_id    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            if (grant_fire) begin
                op_q.a    <= grant_id ? req1_a    : req0_a;
                op_q.b    <= grant_id ? req1_b    : req0_b;
                op_q.aluc <= grant_id ? req1_aluc : req0_aluc;
                op_q.id   <= grant_id;
                prio      <= ~grant_id;
            end
            if (state == EXEC) begin
                resp_c     <= sh_c;
                resp_id    <= op_q.id;
                resp_valid <= 1'b1;
            end else if (resp_fire) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Shifter inputs come straight from flops so the shared shifter never sees grant glitches.
    assign sh_a    = op_q.a;
    assign sh_b    = op_q.b;
    assign sh_aluc = op_q.aluc;

endmodule
